// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin write arbiter with credit tracking for a downstream FIFO
// Optional burst mode is compiled in with FIFO_ARB_BURST_EN.
module fifo_write_arbiter #(
    parameter int DATA_SIZE = 16,
    parameter int NUM_PORTS = 4,
    parameter int SIZE      = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic                              i_en,
    input  logic [NUM_PORTS-1:0]              i_req,
    input  logic [NUM_PORTS*DATA_SIZE-1:0]    i_data,
    output logic [NUM_PORTS-1:0]              o_ack,
    output logic                              o_fifo_write,
    output logic [DATA_SIZE-1:0]              o_fifo_data,
    output logic [$clog2(NUM_PORTS)-1:0]      o_grant_id,
    input  logic                              i_fifo_read,
    output logic [$clog2(SIZE):0]             o_credits
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam int CW = $clog2(SIZE) + 1;

    // A burst must allow at least one word; the block below only anchors the parameter.
    if (MAX_BURST < 1) begin : g_max_burst_must_be_positive
    end

`ifdef FIFO_ARB_BURST_EN
    localparam int BW = $clog2(MAX_BURST + 1);
    typedef enum logic [1:0] {IDLE, GRANT, BURST} state_t;
    logic [BW-1:0] burst_cnt, burst_next;
`else
    typedef enum logic [0:0] {IDLE, GRANT} state_t;
`endif

    state_t                 state, state_next;
    logic [PW-1:0]          rr_ptr, rr_next;
    logic [PW-1:0]          rr_sel, sel;
    logic                   grant;
    logic                   read_ok;
    logic [CW-1:0]          credits, credits_next;
    logic [DATA_SIZE-1:0]   words [NUM_PORTS];

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            words[p] = i_data[p*DATA_SIZE +: DATA_SIZE];
        end
    end

    // Descending search so the nearest requester after rr_ptr is the last to be written.
    always_comb begin
        int idx;
        rr_sel = '0;
        idx    = 0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_PORTS;
            if (i_req[PW'(idx)]) begin
                rr_sel = PW'(idx);
            end
        end
    end

    always_comb begin
        grant      = 1'b0;
        sel        = rr_sel;
        state_next = state;
        rr_next    = rr_ptr;
`ifdef FIFO_ARB_BURST_EN
        burst_next = burst_cnt;
`endif
        if (i_en) begin
            state_next = IDLE;
`ifdef FIFO_ARB_BURST_EN
            burst_next = '0;
`endif
            if (|i_req && credits != '0) begin
                grant = 1'b1;
`ifdef FIFO_ARB_BURST_EN
                if (state == BURST && i_req[rr_ptr] && burst_cnt < BW'(MAX_BURST)) begin
                    sel        = rr_ptr;
                    burst_next = burst_cnt + BW'(1);
                end else begin
                    sel        = rr_sel;
                    burst_next = BW'(1);
                end
                state_next = BURST;
`else
                state_next = GRANT;
`endif
                rr_next = sel;
            end
        end
    end

    // A read that coincides with a grant always cancels it, even at full credit.
    always_comb begin
        read_ok      = i_fifo_read && (credits < CW'(SIZE) || grant);
        credits_next = credits;
        if (grant && !read_ok) begin
            credits_next = credits - CW'(1);
        end else if (!grant && read_ok) begin
            credits_next = credits + CW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= IDLE;
            rr_ptr       <= PW'(NUM_PORTS - 1);
            credits      <= CW'(SIZE);
            o_ack        <= '0;
            o_fifo_write <= 1'b0;
            o_fifo_data  <= '0;
            o_grant_id   <= '0;
        end else begin
            state        <= state_next;
            rr_ptr       <= rr_next;
            credits      <= credits_next;
            o_fifo_write <= grant;
            o_ack        <= grant ? (NUM_PORTS'(1) << sel) : '0;
            o_fifo_data  <= grant ? words[sel] : '0;
            o_grant_id   <= grant ? sel : '0;
        end
    end

`ifdef FIFO_ARB_BURST_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            burst_cnt <= '0;
        end else begin
            burst_cnt <= burst_next;
        end
    end
`endif

    assign o_credits = credits;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - directed self-checking bench for fifo_write_arbiter
module tb_fifo_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  req;
    logic [63:0] data;
    logic [3:0]  ack;
    logic        fifo_write;
    logic [15:0] fifo_data;
    logic [1:0]  grant_id;
    logic        fifo_read;
    logic [3:0]  credits;

    int checks = 0;
    int errors = 0;

    fifo_write_arbiter dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_en         (en),
        .i_req        (req),
        .i_data       (data),
        .o_ack        (ack),
        .o_fifo_write (fifo_write),
        .o_fifo_data  (fifo_data),
        .o_grant_id   (grant_id),
        .i_fifo_read  (fifo_read),
        .o_credits    (credits)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int p, input logic [15:0] w);
        data[p*16 +: 16] = w;
    endtask

    task automatic check_grant(input string tag, input int p, input logic [15:0] w, input int cr);
        check({tag, " write"}, 32'(fifo_write), 32'd1);
        check({tag, " id"}, 32'(grant_id), 32'(p));
        check({tag, " ack"}, 32'(ack), 32'(4'b0001 << p));
        check({tag, " data"}, 32'(fifo_data), 32'(w));
        check({tag, " credits"}, 32'(credits), 32'(cr));
    endtask

    task automatic check_idle(input string tag, input int cr);
        check({tag, " write"}, 32'(fifo_write), 32'd0);
        check({tag, " ack"}, 32'(ack), 32'd0);
        check({tag, " data"}, 32'(fifo_data), 32'd0);
        check({tag, " credits"}, 32'(credits), 32'(cr));
    endtask

    initial begin
        int p;
        reset = 1'b1; en = 1'b0; req = '0; data = '0; fifo_read = 1'b0;
        step();
        step();
        check_idle("reset", 8);
        check("reset id", 32'(grant_id), 32'd0);
        reset = 1'b0;
        en    = 1'b1;

        // All four ports requesting until the credits run out.
        for (int i = 0; i < 4; i++) set_word(i, 16'h1000 + 16'(i));
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
            check_grant($sformatf("rr%0d", k), k % 4, 16'h1000 + 16'(k % 4), 7 - k);
        end
        step();
        check_idle("no credit", 0);
        req = 4'b0000;

        // One returned credit allows exactly one grant.
        fifo_read = 1'b1;
        step();
        fifo_read = 1'b0;
        check("credit return", 32'(credits), 32'd1);
        set_word(2, 16'hABCD);
        req = 4'b0100;
        step();
        check_grant("single", 2, 16'hABCD, 0);
        req = 4'b0000;
        step();
        check_idle("after single", 0);

        // Build to 3 credits, then grant and read together.
        fifo_read = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("refill%0d", k), 32'(credits), 32'(k));
        end
        set_word(0, 16'h5A5A);
        req = 4'b0001;
        step();
        check_grant("grant+read", 0, 16'h5A5A, 3);
        req = 4'b0000;
        fifo_read = 1'b0;
        step();
        check_idle("after grant+read", 3);

        // Credits saturate at SIZE.
        fifo_read = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("sat%0d", k), 32'(credits), 32'((k < 5) ? 4 + k : 8));
        end
        fifo_read = 1'b0;

        // Disabled arbitration makes no grants.
        en  = 1'b0;
        req = 4'b1111;
        step();
        check_idle("disabled", 8);
        req = 4'b0000;
        en  = 1'b1;

        // Fresh reset so port 0 has priority for the two-port pattern.
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_word(0, 16'h00A0);
        set_word(1, 16'h00B1);
        req = 4'b0011;
        for (int k = 0; k < 6; k++) begin
            step();
`ifdef FIFO_ARB_BURST_EN
            p = k / 4;
`else
            p = k % 2;
`endif
            check_grant($sformatf("pair%0d", k), p, (p == 0) ? 16'h00A0 : 16'h00B1, 7 - k);
        end

        // Asynchronous reset between edges clears outputs at once.
        #2;
        reset = 1'b1;
        #1;
        check_idle("async reset", 8);
        check("async reset id", 32'(grant_id), 32'd0);
        step();
        reset = 1'b0;
        set_word(1, 16'h1111);
        req = 4'b0110;
        step();
        check_grant("post reset", 1, 16'h1111, 7);
        req = 4'b0000;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
